// File: rtl/bram_cart_pkg.sv
// Shared types and constants for the Mega-CD backup RAM cartridge controller.
// Address windows are 68k byte addresses; the byte index is at most 20 bits wide.
package bram_cart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_HOLD
  } state_t;

  // One action per cycle, chosen by the FSM and applied by the datapath.
  typedef enum logic [3:0] {
    ACT_NONE,
    ACT_REG_RD,
    ACT_BNK_WR,
    ACT_WEN_WR,
    ACT_MEM_RD,
    ACT_MEM_WR,
    ACT_RD_DONE,
    ACT_ACK_DROP,
    ACT_RELEASE
  } act_t;

  localparam logic [23:0] WIN_MASK = 24'hF0_0000;
  localparam logic [23:0] ID_BASE  = 24'h40_0000;
  localparam logic [23:0] DAT_BASE = 24'h60_0000;
  localparam logic [23:0] BNK_ADDR = 24'h7F_FFFC;
  localparam logic [23:0] WEN_ADDR = 24'h7F_FFFE;
  localparam int          IDX_W    = 20;

  function automatic int unsigned size_to_cap(input int unsigned size_code);
    return 32'd8192 << size_code;
  endfunction

endpackage

// File: rtl/bram_cart_decode.sv
// Combinational 68k address decode into the four cart windows plus the
// capacity-wrapped cart byte index (one cart byte per odd 68k address).
module bram_cart_decode
  import bram_cart_pkg::*;
#(
  parameter int SIZE_CODE = 4
) (
  input  logic [23:0]      i_addr,
  output logic             o_win_id,
  output logic             o_win_dat,
  output logic             o_win_bnk,
  output logic             o_win_wen,
  output logic [IDX_W-1:0] o_idx
);

  localparam int unsigned      CAP      = size_to_cap(SIZE_CODE);
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(CAP - 1);

  logic w_unused;

  assign o_win_id  = (i_addr & WIN_MASK) == ID_BASE;
  assign o_win_dat = (i_addr & WIN_MASK) == DAT_BASE;
  assign o_win_bnk = i_addr[23:1] == BNK_ADDR[23:1];
  assign o_win_wen = i_addr[23:1] == WEN_ADDR[23:1];
  assign o_idx     = i_addr[20:1] & IDX_MASK;

  assign w_unused  = i_addr[0];

endmodule

// File: rtl/bram_cart_ctrl.sv
// Backup RAM cart controller: decodes 68k cycles, serves the ID/bank/write-enable
// registers locally and serialises data-window accesses onto a req/ack memory port.
module bram_cart_ctrl
  import bram_cart_pkg::*;
#(
  parameter int SIZE_CODE = 4,
  parameter int NUM_BANKS = 1,
  parameter int MEM_AW    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cart_on,
  input  logic [23:0]       cpu_addr,
  input  logic [15:0]       cpu_dat,
  input  logic              cpu_as_n,
  input  logic              cpu_oe_n,
  input  logic              cpu_we_lo_n,
  input  logic              cpu_we_hi_n,
  output logic [15:0]       cart_dout,
  output logic              cart_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ack,
  output logic              dirty,
  input  logic              dirty_clr
);

  localparam logic [3:0] BANK_MASK = 4'(NUM_BANKS - 1);

  state_t            r_state, w_state_nxt;
  act_t              w_act;
  logic              w_win_id, w_win_dat, w_win_bnk, w_win_wen;
  logic [IDX_W-1:0]  w_idx;
  logic [MEM_AW-1:0] w_word;
  logic [15:0]       w_reg_val;
  logic              w_start, w_lost, w_set_dirty, w_unused;
  logic              r_oe_n_q, r_we_lo_n_q, r_we_hi_n_q;
  logic              r_wr_en, r_lane, r_lost, r_cart_oe, r_dirty;
  logic [3:0]        r_bank;
  logic [15:0]       r_cart_dout, r_mem_din;
  logic              r_mem_req, r_mem_we;
  logic [1:0]        r_mem_be;
  logic [MEM_AW-1:0] r_mem_addr;

  bram_cart_decode #(.SIZE_CODE(SIZE_CODE)) u_decode (
    .i_addr    (cpu_addr),
    .o_win_id  (w_win_id),
    .o_win_dat (w_win_dat),
    .o_win_bnk (w_win_bnk),
    .o_win_wen (w_win_wen),
    .o_idx     (w_idx)
  );

  assign w_word = (MEM_AW'(r_bank) << (12 + SIZE_CODE)) | MEM_AW'(w_idx >> 1);

  assign w_reg_val = w_win_id  ? {8'hFF, 8'(SIZE_CODE)} :
                     w_win_bnk ? {8'hFF, 4'h0, r_bank}  :
                                 {8'hFF, 7'h0, r_wr_en};

  // A cycle starts on the first clock that sees any strobe newly asserted.
  assign w_start = cart_on && !cpu_as_n
                && ((r_oe_n_q && !cpu_oe_n) || (r_we_lo_n_q && !cpu_we_lo_n)
                    || (r_we_hi_n_q && !cpu_we_hi_n))
                && (w_win_id || w_win_dat || w_win_bnk || w_win_wen);

  assign w_lost      = r_lost || cpu_as_n || !cart_on;
  assign w_set_dirty = (r_state == S_WR) && mem_ack;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    w_act       = ACT_NONE;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state_nxt = S_HOLD;
        if (!cpu_oe_n) begin
          if (w_win_dat) begin
            w_act       = ACT_MEM_RD;
            w_state_nxt = S_RD;
          end else begin
            w_act = ACT_REG_RD;
          end
        end else if (!cpu_we_lo_n) begin
          if (w_win_dat && r_wr_en) begin
            w_act       = ACT_MEM_WR;
            w_state_nxt = S_WR;
          end else if (w_win_bnk) begin
            w_act = ACT_BNK_WR;
          end else if (w_win_wen) begin
            w_act = ACT_WEN_WR;
          end
        end
      end
      S_RD: if (mem_ack) begin
        w_act       = w_lost ? ACT_ACK_DROP : ACT_RD_DONE;
        w_state_nxt = w_lost ? S_IDLE : S_HOLD;
      end
      S_WR: if (mem_ack) begin
        w_act       = ACT_ACK_DROP;
        w_state_nxt = w_lost ? S_IDLE : S_HOLD;
      end
      S_HOLD: if (cpu_as_n || !cart_on) begin
        w_act       = ACT_RELEASE;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oe_n_q    <= 1'b1;
      r_we_lo_n_q <= 1'b1;
      r_we_hi_n_q <= 1'b1;
      r_cart_dout <= 16'hFFFF;
      r_cart_oe   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_din   <= 16'h0000;
      r_dirty     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_bank      <= 4'h0;
      r_lane      <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_oe_n_q    <= cpu_oe_n;
      r_we_lo_n_q <= cpu_we_lo_n;
      r_we_hi_n_q <= cpu_we_hi_n;
      // Remember a dropped strobe so a re-asserted one cannot claim stale read data.
      r_lost      <= (r_state == S_RD || r_state == S_WR) && !mem_ack && w_lost;
      case (w_act)
        ACT_REG_RD: begin
          r_cart_dout <= w_reg_val;
          r_cart_oe   <= 1'b1;
        end
        ACT_BNK_WR: r_bank  <= cpu_dat[3:0] & BANK_MASK;
        ACT_WEN_WR: r_wr_en <= cpu_dat[0];
        ACT_MEM_RD: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_be   <= 2'b11;
          r_mem_addr <= w_word;
          r_lane     <= w_idx[0];
        end
        ACT_MEM_WR: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b1;
          r_mem_be   <= w_idx[0] ? 2'b10 : 2'b01;
          r_mem_addr <= w_word;
          r_mem_din  <= {cpu_dat[7:0], cpu_dat[7:0]};
          r_lane     <= w_idx[0];
        end
        ACT_RD_DONE: begin
          r_mem_req   <= 1'b0;
          r_cart_dout <= {8'hFF, r_lane ? mem_dout[15:8] : mem_dout[7:0]};
          r_cart_oe   <= 1'b1;
        end
        ACT_ACK_DROP: r_mem_req <= 1'b0;
        ACT_RELEASE:  r_cart_oe <= 1'b0;
        default: ;
      endcase
      if (w_set_dirty)    r_dirty <= 1'b1;
      else if (dirty_clr) r_dirty <= 1'b0;
    end
  end

  assign cart_dout = r_cart_dout;
  assign cart_oe   = r_cart_oe && cart_on;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign dirty     = r_dirty;

  assign w_unused  = &{1'b0, cpu_dat[15:8]};

endmodule

// File: tb/tb_bram_cart_ctrl.sv
// Directed bench for bram_cart_ctrl: instance A (SIZE_CODE=4, 4 banks) and
// instance B (SIZE_CODE=0, 1 bank) share the 68k bus; each has its own memory responder.
module tb_bram_cart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] cpu_addr = 24'h0;
  logic [15:0] cpu_dat = 16'h0;
  logic        cpu_as_n = 1'b1, cpu_oe_n = 1'b1, cpu_we_lo_n = 1'b1, cpu_we_hi_n = 1'b1;
  logic        dirty_clr = 1'b0;

  logic        cart_on_a = 1'b1, cart_oe_a, mem_req_a, mem_we_a, mem_ack_a = 1'b0, dirty_a;
  logic [15:0] cart_dout_a, mem_din_a, mem_dout_a = 16'h0;
  logic [1:0]  mem_be_a;
  logic [17:0] mem_addr_a;

  logic        cart_on_b = 1'b0, cart_oe_b, mem_req_b, mem_we_b, mem_ack_b = 1'b0, dirty_b;
  logic [15:0] cart_dout_b, mem_din_b, mem_dout_b = 16'h0;
  logic [1:0]  mem_be_b;
  logic [17:0] mem_addr_b;

  int n_total = 0, n_bad = 0;
  int lat_a = 1, cnt_a = 0, acks_a = 0, req_cyc_a = 0, cnt_b = 0;
  logic [15:0] rdata_a = 16'h0, rdata_b = 16'h0;

  always #5 clk = ~clk;

  bram_cart_ctrl #(.SIZE_CODE(4), .NUM_BANKS(4), .MEM_AW(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .cart_on(cart_on_a), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .cpu_as_n(cpu_as_n), .cpu_oe_n(cpu_oe_n), .cpu_we_lo_n(cpu_we_lo_n), .cpu_we_hi_n(cpu_we_hi_n),
    .cart_dout(cart_dout_a), .cart_oe(cart_oe_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_be(mem_be_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_dout(mem_dout_a),
    .mem_ack(mem_ack_a), .dirty(dirty_a), .dirty_clr(dirty_clr)
  );

  bram_cart_ctrl #(.SIZE_CODE(0), .NUM_BANKS(1), .MEM_AW(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .cart_on(cart_on_b), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .cpu_as_n(cpu_as_n), .cpu_oe_n(cpu_oe_n), .cpu_we_lo_n(cpu_we_lo_n), .cpu_we_hi_n(cpu_we_hi_n),
    .cart_dout(cart_dout_b), .cart_oe(cart_oe_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_be(mem_be_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b),
    .mem_ack(mem_ack_b), .dirty(dirty_b), .dirty_clr(1'b0)
  );

  // Memory responders: ack lat cycles after mem_req is first seen, one-cycle pulse.
  always @(negedge clk) begin
    if (mem_req_a) req_cyc_a++;
    if (mem_ack_a) begin
      mem_ack_a = 1'b0;
      cnt_a     = 0;
    end else if (mem_req_a) begin
      cnt_a++;
      if (cnt_a >= lat_a) begin
        mem_ack_a  = 1'b1;
        mem_dout_a = rdata_a;
        acks_a++;
      end
    end else begin
      cnt_a = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_ack_b) begin
      mem_ack_b = 1'b0;
      cnt_b     = 0;
    end else if (mem_req_b) begin
      mem_ack_b  = 1'b1;
      mem_dout_b = rdata_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [23:0] a, input logic [15:0] d, input bit rd, input bit we_lo,
                    input bit we_hi);
    @(negedge clk);
    cpu_addr    = a;
    cpu_dat     = d;
    cpu_as_n    = 1'b0;
    cpu_oe_n    = !rd;
    cpu_we_lo_n = !we_lo;
    cpu_we_hi_n = !we_hi;
  endtask

  task automatic drop_strobes();
    cpu_as_n    = 1'b1;
    cpu_oe_n    = 1'b1;
    cpu_we_lo_n = 1'b1;
    cpu_we_hi_n = 1'b1;
  endtask

  task automatic release_bus();
    @(negedge clk);
    drop_strobes();
    @(negedge clk);
  endtask

  task automatic wait_oe(input bit on_b, output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (on_b ? cart_oe_b : cart_oe_a) break;
    end
  endtask

  // Single-cycle register read on instance A, checked one cycle after the strobe.
  task automatic reg_read_a(input string tag, input logic [23:0] a, input logic [15:0] exp);
    go(a, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, "_oe"}, cart_oe_a, 1);
    check(tag, cart_dout_a, exp);
    release_bus();
  endtask

  task automatic write_a(input logic [23:0] a, input logic [15:0] d);
    go(a, d, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    release_bus();
  endtask

  initial begin
    int n;
    int snap;
    bit seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dout", cart_dout_a, 16'hFFFF);
    check("rst_oe", cart_oe_a, 0);
    check("rst_req", mem_req_a, 0);
    check("rst_we", mem_we_a, 0);
    check("rst_be", mem_be_a, 0);
    check("rst_addr", mem_addr_a, 0);
    check("rst_din", mem_din_a, 0);
    check("rst_dirty", dirty_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ID register, then cart_oe clears once the strobe goes away
    reg_read_a("id", 24'h400000, 16'hFF04);
    check("id_oe_clear", cart_oe_a, 0);
    reg_read_a("wen_rst", 24'h7FFFFE, 16'hFF00);
    reg_read_a("bnk_rst", 24'h7FFFFC, 16'hFF00);

    // Data write while write-protected: no request, stays clean
    snap = req_cyc_a;
    go(24'h600000, 16'h00A5, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    release_bus();
    check("wp_no_req", req_cyc_a - snap, 0);
    check("wp_dirty", dirty_a, 0);

    // Enable writes, byte write to $600005 (index 2 -> word 1, low lane)
    write_a(24'h7FFFFE, 16'h0001);
    reg_read_a("wen_set", 24'h7FFFFE, 16'hFF01);
    go(24'h600004, 16'h005A, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("wr_req", mem_req_a, 1);
    check("wr_we", mem_we_a, 1);
    check("wr_addr", mem_addr_a, 18'h00001);
    check("wr_be", mem_be_a, 2'b01);
    check("wr_din", mem_din_a, 16'h5A5A);
    @(negedge clk);
    check("wr_done_req", mem_req_a, 0);
    check("wr_dirty", dirty_a, 1);
    release_bus();

    // High-byte-only write is ignored
    snap = req_cyc_a;
    go(24'h600004, 16'h3300, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    release_bus();
    check("hi_only_no_req", req_cyc_a - snap, 0);

    // Data reads: low lane then high lane
    rdata_a = 16'h775A;
    go(24'h600004, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rd_req", mem_req_a, 1);
    check("rd_we", mem_we_a, 0);
    check("rd_be", mem_be_a, 2'b11);
    check("rd_addr", mem_addr_a, 18'h00001);
    wait_oe(1'b0, n);
    check("rd_lat", n, 1);
    check("rd_lo_dout", cart_dout_a, 16'hFF5A);
    release_bus();
    go(24'h600002, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rd_hi_addr", mem_addr_a, 18'h00000);
    wait_oe(1'b0, n);
    check("rd_hi_oe", cart_oe_a, 1);
    check("rd_hi_dout", cart_dout_a, 16'hFF77);
    release_bus();

    // Bank select, masked to NUM_BANKS-1, lands above the 16-bit word index
    write_a(24'h7FFFFC, 16'h0006);
    reg_read_a("bnk2", 24'h7FFFFC, 16'hFF02);
    go(24'h600004, 16'h0011, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("bnk_addr", mem_addr_a, 18'h20001);
    check("bnk_field", mem_addr_a[17:16], 2'b10);
    @(negedge clk);
    release_bus();
    write_a(24'h7FFFFC, 16'h000F);
    reg_read_a("bnk_mask", 24'h7FFFFC, 16'hFF03);
    write_a(24'h7FFFFC, 16'h0000);

    // Strobe lost mid-read: handshake completes, no data presented
    lat_a = 5;
    snap  = acks_a;
    seen  = 1'b0;
    go(24'h600004, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drop_strobes();
    repeat (10) begin
      @(negedge clk);
      if (cart_oe_a) seen = 1'b1;
    end
    check("lost_oe", seen, 0);
    check("lost_req", mem_req_a, 0);
    check("lost_acks", acks_a - snap, 1);
    lat_a = 1;
    reg_read_a("after_lost", 24'h400000, 16'hFF04);

    // dirty_clr alone clears; coincident with a write ack the set wins
    @(negedge clk);
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    check("clr_dirty", dirty_a, 0);
    go(24'h600004, 16'h0033, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    check("set_wins", dirty_a, 1);
    release_bus();

    // Instance B (8K cart), A disabled: A must stay silent
    cart_on_a = 1'b0;
    cart_on_b = 1'b1;
    snap      = req_cyc_a;
    rdata_b   = 16'h12AB;
    go(24'h400000, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_id", cart_dout_b, 16'hFF00);
    check("a_off_oe", cart_oe_a, 0);
    release_bus();
    go(24'h600000, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_rd0_addr", mem_addr_b, 18'h0);
    wait_oe(1'b1, n);
    check("b_rd0_dout", cart_dout_b, 16'hFFAB);
    release_bus();
    go(24'h604000, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_wrap_addr", mem_addr_b, 18'h0);
    wait_oe(1'b1, n);
    check("b_wrap_dout", cart_dout_b, 16'hFFAB);
    release_bus();
    go(24'h600002, 16'h0, 1'b1, 1'b0, 1'b0);
    wait_oe(1'b1, n);
    check("b_hi_dout", cart_dout_b, 16'hFF12);
    release_bus();
    check("a_off_no_req", req_cyc_a - snap, 0);
    cart_on_b = 1'b0;
    cart_on_a = 1'b1;

    // Reset during an outstanding request drops it and clears the registers
    lat_a = 5;
    go(24'h600004, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_req", mem_req_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_drop_req", mem_req_a, 0);
    drop_strobes();
    @(negedge clk);
    rst_n = 1'b1;
    lat_a = 1;
    @(negedge clk);
    reg_read_a("wen_after_rst", 24'h7FFFFE, 16'hFF00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
